// File: rtl/pulse_handshake_tx.sv
// Source-domain launcher: turns per-channel event pulses into held request levels
// closed by a four-phase req/ack handshake, queuing overlapping events per channel.
module pulse_handshake_tx #(
    parameter int unsigned SIZE   = 4,
    parameter int unsigned PEND_W = 2
) (
    input  logic            src_clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pulse_in,
    input  logic [SIZE-1:0] ack_in,
    output logic [SIZE-1:0] signal_out,
    output logic [SIZE-1:0] busy,
    output logic [SIZE-1:0] overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKLO = 2'd2
    } state_t;

    state_t            state_q [SIZE];
    state_t            state_d [SIZE];
    logic [PEND_W-1:0] pend_q  [SIZE];
    logic [PEND_W-1:0] pend_d  [SIZE];
    logic [SIZE-1:0]   ack_s1_q, ack_s2_q;
    logic [SIZE-1:0]   sig_q, sig_d;
    logic [SIZE-1:0]   ovf_q, ovf_d;
    logic [SIZE-1:0]   from_pend, inc;

    always_comb begin
        from_pend = '0;
        inc       = '0;
        sig_d     = '0;
        ovf_d     = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];

            // A pulse only bypasses the queue when the channel is idle with nothing pending.
            from_pend[i] = (state_q[i] == IDLE) && (pend_q[i] != '0);
            inc[i]       = pulse_in[i] && !((state_q[i] == IDLE) && (pend_q[i] == '0));

            if (inc[i] && !from_pend[i]) begin
                if (pend_q[i] == '1) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end
            end else if (from_pend[i] && !inc[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end

            unique case (state_q[i])
                IDLE:    if (pulse_in[i] || (pend_q[i] != '0)) state_d[i] = REQ;
                REQ:     if (ack_s2_q[i])  state_d[i] = ACKLO;
                ACKLO:   if (!ack_s2_q[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase

            sig_d[i] = (state_d[i] == REQ);
        end
    end

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            ack_s1_q <= '0;
            ack_s2_q <= '0;
            sig_q    <= '0;
            ovf_q    <= '0;
            for (int unsigned i = 0; i < SIZE; i++) begin
                state_q[i] <= IDLE;
                pend_q[i]  <= '0;
            end
        end else begin
            ack_s1_q <= ack_in;
            ack_s2_q <= ack_s1_q;
            sig_q    <= sig_d;
            ovf_q    <= ovf_d;
            for (int unsigned i = 0; i < SIZE; i++) begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            busy[i] = (state_q[i] != IDLE) || (pend_q[i] != '0);
        end
    end

    assign signal_out = sig_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Source-domain launcher that pairs with the destination-side double-flop synchronizer / pulse generator in the async FIFO clock-crossing path. It turns single-cycle event pulses on `src_clk` into held request levels, one per channel. Each level stays high until the destination acknowledges it through a four-phase req/ack handshake, so the destination's rising-edge detector produces exactly one pulse per event. Events that arrive while a channel is mid-handshake are queued in a per-channel saturating pending counter.

## Interface
Parameters:
- `SIZE`, 4, number of independent channels (bit lanes).
- `PEND_W`, 2, pending-counter width per channel; the queue holds up to 2^PEND_W − 1 events.

Ports (one clock; reset is asynchronous and active-high):
- `src_clk`  input  1  source-domain clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `pulse_in`  input  SIZE  one-cycle event strobe per channel, synchronous to `src_clk`.
- `ack_in`  input  SIZE  per-channel acknowledge level from the destination domain. It is asynchronous to `src_clk` and is synchronized internally.
- `signal_out`  output  SIZE  registered request level per channel; this drives the destination synchronizer's `signal_in`.
- `busy`  output  SIZE  channel is mid-handshake or has queued events.
- `overflow`  output  SIZE  one-cycle strobe: an event on this channel was dropped.

## Operation
- **Ack synchronizer.** Each channel has two flops: `ack_s1` then `ack_s2`. Only `ack_s2` is used by the FSM.
- **Per-channel FSM.** Three states: IDLE, REQ, ACKLO. Every channel runs independently.
  - IDLE: `signal_out`=0. If `pulse_in`=1 or `pending`≠0, go to REQ.
  - REQ: `signal_out`=1. If `ack_s2`=1, go to ACKLO.
  - ACKLO: `signal_out`=0. If `ack_s2`=0, go to IDLE.
- **`signal_out` is a register**, equal to 1 exactly while the channel is in REQ. It is never combinational from any input.
- **Launch source.** In IDLE, a launch consumes `pending` first when it is nonzero; otherwise it consumes the current `pulse_in`.
- **Pending counter, per channel (unsigned, PEND_W bits).**
  - +1 when `pulse_in`=1 and that pulse does not launch this cycle.
  - −1 when a launch is taken from `pending`.
  - A pulse in the same cycle as a launch-from-pending: net change 0.
  - Saturation: a pulse arriving with `pending`=2^PEND_W−1 and no decrement that cycle is dropped. `overflow` then goes to 1 for one cycle and `pending` stays unchanged.
  - The counter never wraps.
- **`busy` = (state≠IDLE) | (`pending`≠0)**, registered-state derived.
- **Reset** (asynchronous, any time, including mid-handshake):
  - state=IDLE, `pending`=0, `ack_s1`=`ack_s2`=0.
  - `signal_out`=0, `busy`=0, `overflow`=0.
  - A handshake in flight is abandoned; the destination domain must be reset alongside.

## Timing
- **Launch latency.** `pulse_in` high in cycle N with the channel IDLE and `pending`=0: `signal_out` rises at edge N+1.
- **Ack path.** `ack_in` change to `ack_s2`: 2 `src_clk` edges. `signal_out` falls 1 edge after `ack_s2` is seen high. The REQ→ACKLO decision uses `ack_s2` sampled in REQ.
- **Minimum per-event cycle time on the source side:** 1 (launch) + 2 (ack sync rise) + 1 + 2 (ack sync fall) + 1 (return to IDLE) = 7 `src_clk` cycles, plus destination-side latency.
- **Destination contract.** The destination drives `ack_in` from its synchronized copy of `signal_out`. `ack_in` therefore rises only after the destination has captured the high level and falls only after it has captured the low level, which guarantees one destination pulse per launch.
- **Low-time guarantee.** `signal_out` is low for at least 3 `src_clk` cycles between consecutive requests: the ACKLO dwell plus the IDLE cycle.
- **Ack violations.**
  - `ack_in` high while in IDLE is ignored; no launch or state change results from it.
  - A glitch on `ack_in` shorter than 2 cycles may be missed. That is legal, because the handshake is level-based.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Release `rst`, pulse ch0 → `signal_out[0]`=1 after exactly 1 edge.
- **Single handshake.** Pulse ch1. Model ack as `signal_out` delayed 3 cycles → `signal_out[1]` high for 1+3+2 = 6 cycles. `busy[1]` clears 1 cycle after `ack_s2` falls. Exactly one rising edge on `signal_out[1]`.
- **Queueing.** With PEND_W=2, pulse ch2 on 4 consecutive cycles → 1 launch plus `pending`=3, no overflow. Complete the handshakes → exactly 4 rising edges on `signal_out[2]`, then `busy[2]`=0.
- **Saturation.** With PEND_W=2, pulse ch3 on 6 consecutive cycles while the ack is held low → `overflow[3]` strobes on cycles 5 and 6 only, and `pending` stays at 3. After ack release → 4 launches total.
- **Simultaneous events.** Pulse ch0 in the same cycle ch0 launches from `pending`=1 → `pending` stays 1. Pulses on all SIZE channels together → independent, identical timing per channel.
- **Reset mid-handshake.** Assert `rst` while ch0 is in REQ with `pending`=2 → `signal_out[0]`=0, `busy[0]`=0, and queued events are discarded. After release, `ack_in` held high with no pulse → no launch.
